// File: rtl/hint_bit_unpack.sv
// hint_bit_unpack: decodes the W+K byte ML-DSA hint encoding into K x 256 hint bits.
// It examines one encoded byte per clock and flags every malformed encoding on fail.
// Optional build macro HBU_CONST_TIME_EN: failing inputs hold in FAIL_END until the
// success latency has elapsed, so endpin rises 2K+W+3 edges after start for any input.
module hint_bit_unpack #(
  parameter int K = 8,
  parameter int W = 75
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  startpin,
  input  logic [8*(W+K)-1:0]    y,
  output logic [K-1:0][255:0]   h,
  output logic                  fail,
  output logic                  endpin
);

  localparam int YW = 8 * (W + K);
  localparam int IW = $clog2(K) + 1;
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam logic [7:0]    W_B   = 8'(W);
  localparam logic [IW-1:0] K_I   = IW'(K);
  localparam logic [IW-1:0] ONE_I = IW'(1);

`ifdef HBU_CONST_TIME_EN
  localparam int CW = $clog2(2 * K + W + 4) + 1;
  localparam logic [CW-1:0] CNT_TARGET = CW'(2 * K + W + 2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROW      = 3'd1,
    S_DECODE   = 3'd2,
    S_TAIL     = 3'd3,
    S_FAIL_END = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Byte b of the latched encoding.
  function automatic logic [7:0] get_byte(input logic [YW-1:0] v, input int b);
    return v[8*b +: 8];
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [YW-1:0]          y_r, y_nxt_s;
  logic [K-1:0][255:0]    h_r, h_nxt_s;
  logic                   fail_r, fail_nxt_s;
  logic                   end_r, end_nxt_s;
  logic [7:0]             index_r, index_nxt_s;
  logic [IW-1:0]          i_r, i_nxt_s;
  logic [7:0]             rowstart_r, rowstart_nxt_s;
  logic [7:0]             limit_r, limit_nxt_s;
`ifdef HBU_CONST_TIME_EN
  logic [CW-1:0]          cnt_r, cnt_nxt_s;
`endif

  logic [RW-1:0]          row_s;
  logic [7:0]             lim_s;
  logic [7:0]             pos_s;
  logic [7:0]             prev_idx_s;
  logic [7:0]             prev_s;

  // Bytes inspected this cycle: row limit for row i, position at index and its predecessor.
  always_comb begin
    row_s      = i_r[RW-1:0];
    lim_s      = get_byte(y_r, W + int'(row_s));
    pos_s      = get_byte(y_r, int'(index_r));
    prev_idx_s = (index_r == 8'd0) ? 8'd0 : (index_r - 8'd1);
    prev_s     = get_byte(y_r, int'(prev_idx_s));
  end

  // Next-state and next-datapath decisions for the decode walk.
  always_comb begin
    state_nxt_s    = state_r;
    y_nxt_s        = y_r;
    h_nxt_s        = h_r;
    fail_nxt_s     = fail_r;
    end_nxt_s      = end_r;
    index_nxt_s    = index_r;
    i_nxt_s        = i_r;
    rowstart_nxt_s = rowstart_r;
    limit_nxt_s    = limit_r;
`ifdef HBU_CONST_TIME_EN
    // Counter reads n+1 in the cycle after edge n (edge 0 = start acceptance).
    if ((state_r != S_IDLE) && (state_r != S_DONE)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
`endif
    case (state_r)
      S_IDLE: begin
        if (startpin) begin
          y_nxt_s     = y;
          h_nxt_s     = '0;
          fail_nxt_s  = 1'b0;
          end_nxt_s   = 1'b0;
          index_nxt_s = 8'd0;
          i_nxt_s     = '0;
          state_nxt_s = S_ROW;
`ifdef HBU_CONST_TIME_EN
          cnt_nxt_s   = CNT_ONE;
`endif
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ROW: begin
        if (i_r == K_I) begin
          state_nxt_s = S_TAIL;
        end else begin
          limit_nxt_s = lim_s;
          // Cumulative limits must be non-decreasing and never exceed W.
          if ((lim_s < index_r) || (lim_s > W_B)) begin
            fail_nxt_s  = 1'b1;
            state_nxt_s = S_FAIL_END;
          end else begin
            rowstart_nxt_s = index_r;
            state_nxt_s    = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (index_r == limit_r) begin
          i_nxt_s     = i_r + ONE_I;
          state_nxt_s = S_ROW;
        end else if ((index_r > rowstart_r) && (pos_s <= prev_s)) begin
          // Positions inside a row must be strictly increasing; the first one is exempt.
          fail_nxt_s  = 1'b1;
          state_nxt_s = S_FAIL_END;
        end else begin
          h_nxt_s[row_s][pos_s] = 1'b1;
          index_nxt_s           = index_r + 8'd1;
        end
      end
      S_TAIL: begin
        if (index_r == W_B) begin
          state_nxt_s = S_DONE;
        end else if (pos_s != 8'd0) begin
          fail_nxt_s  = 1'b1;
          state_nxt_s = S_FAIL_END;
        end else begin
          index_nxt_s = index_r + 8'd1;
        end
      end
      S_FAIL_END: begin
        // Never expose partially decoded hints of a rejected encoding.
        h_nxt_s = '0;
`ifdef HBU_CONST_TIME_EN
        if (cnt_r >= CNT_TARGET) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_FAIL_END;
        end
`else
        state_nxt_s = S_DONE;
`endif
      end
      S_DONE: begin
        end_nxt_s = 1'b1;
        if (!startpin) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r        <= '0;
      h_r        <= '0;
      fail_r     <= 1'b0;
      end_r      <= 1'b0;
      index_r    <= 8'd0;
      i_r        <= '0;
      rowstart_r <= 8'd0;
      limit_r    <= 8'd0;
`ifdef HBU_CONST_TIME_EN
      cnt_r      <= '0;
`endif
    end else begin
      y_r        <= y_nxt_s;
      h_r        <= h_nxt_s;
      fail_r     <= fail_nxt_s;
      end_r      <= end_nxt_s;
      index_r    <= index_nxt_s;
      i_r        <= i_nxt_s;
      rowstart_r <= rowstart_nxt_s;
      limit_r    <= limit_nxt_s;
`ifdef HBU_CONST_TIME_EN
      cnt_r      <= cnt_nxt_s;
`endif
    end
  end

  assign h      = h_r;
  assign fail   = fail_r;
  assign endpin = end_r;

endmodule

// File: tb/tb_hint_bit_unpack.sv
// Self-checking bench for hint_bit_unpack: behavioural HintBitUnpack model,
// directed malformed cases, reset/handshake scenarios and random encodings.
module tb_hint_bit_unpack;
  localparam int K  = 8;
  localparam int W  = 75;
  localparam int YW = 8 * (W + K);
  localparam int HW = K * 256;

  logic                clk = 1'b0;
  logic                rst;
  logic                startpin;
  logic [YW-1:0]       y;
  logic [K-1:0][255:0] h;
  logic                fail;
  logic                endpin;

  always #5 clk = ~clk;

  hint_bit_unpack #(.K(K), .W(W)) dut (
    .clk(clk), .rst(rst), .startpin(startpin), .y(y),
    .h(h), .fail(fail), .endpin(endpin)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [HW-1:0] exp_h;
  logic          exp_fail;
  bit            exp_valid = 1'b0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  function automatic int popc(input logic [HW-1:0] v);
    int c = 0;
    for (int b = 0; b < HW; b++) if (v[b]) c++;
    return c;
  endfunction

  task automatic chk_h(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: h popcount %0d, expected popcount %0d (contents differ)",
                  nm, popc(act), popc(req));
  endtask

  // Reference HintBitUnpack; also counts clock edges to endpin from the walk's steps.
  task automatic model(input logic [YW-1:0] v, output logic [HW-1:0] eh,
                       output logic ef, output int lat);
    int b [W+K];
    int idx, e, first, fe;
    bit bad;
    for (int n = 0; n < W + K; n++) b[n] = int'(v[8*n +: 8]);
    eh = '0; bad = 1'b0; idx = 0; e = 0; fe = 0; first = 0;
    for (int r = 0; r < K && !bad; r++) begin
      e++;
      if (b[W+r] < idx || b[W+r] > W) begin
        bad = 1'b1; fe = e;
      end else begin
        first = idx;
        while (idx < b[W+r] && !bad) begin
          e++;
          if (idx > first && b[idx] <= b[idx-1]) begin
            bad = 1'b1; fe = e;
          end else begin
            eh[r*256 + b[idx]] = 1'b1;
            idx++;
          end
        end
        if (!bad) e++;
      end
    end
    if (!bad) begin
      e++;
      while (idx < W && !bad) begin
        e++;
        if (b[idx] != 0) begin bad = 1'b1; fe = e; end
        else idx++;
      end
      if (!bad) e++;
    end
    ef = bad;
    if (bad) eh = '0;
    lat = bad ? fe + 2 : e + 1;
`ifdef HBU_CONST_TIME_EN
    lat = 2 * K + W + 3;
`endif
  endtask

  // Compare process: whenever a result is presented, it must match the model.
  always @(posedge clk) begin
    #1;
    if (exp_valid && endpin) begin
      chk("fail_out", longint'(fail), longint'(exp_fail));
      chk_h("h_out", h, exp_h);
    end
  end

  function automatic logic [YW-1:0] rand_y();
    logic [YW-1:0] v;
    for (int n = 0; n < W + K; n++) v[8*n +: 8] = 8'($urandom);
    return v;
  endfunction

  // Start one decode (startpin pulse), scramble y afterwards, check latency.
  task automatic run_case(input logic [YW-1:0] v, input string nm);
    logic [HW-1:0] mh; logic mf; int ml; int cyc;
    model(v, mh, mf, ml);
    @(negedge clk);
    exp_h = mh; exp_fail = mf; exp_valid = 1'b1;
    y = v; startpin = 1'b1;
    @(posedge clk); #1;
    chk({nm, " endpin_clear"}, longint'(endpin), 0);
    @(negedge clk);
    startpin = 1'b0; y = rand_y();
    cyc = 1;
    @(posedge clk); #1;
    while (!endpin && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc, ml);
  endtask

  task automatic gen_rand(output logic [YW-1:0] v);
    int idx, cnt, p, lim, n;
    v = '0; idx = 0;
    for (int r = 0; r < K; r++) begin
      lim = (W - idx) < 12 ? (W - idx) : 12;
      cnt = int'($urandom_range(0, lim));
      p = int'($urandom_range(0, 7));
      for (int j = 0; j < cnt; j++) begin
        v[8*idx +: 8] = 8'(p);
        idx++;
        p = p + 1 + int'($urandom_range(0, 15));
      end
      v[8*(W+r) +: 8] = 8'(idx);
    end
    if ($urandom_range(0, 1) == 1) begin
      n = int'($urandom_range(0, W + K - 1));
      v[8*n +: 8] = 8'($urandom);
    end
  endtask

  initial begin
    logic [YW-1:0] v, v3;
    logic [HW-1:0] mh; logic mf; int ml; int cyc;

    rst = 1'b1; startpin = 1'b0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset endpin", longint'(endpin), 0);
    chk("reset fail", longint'(fail), 0);
    chk("reset h_pop", popc(h), 0);
    @(negedge clk); rst = 1'b0;

    // Pin the model with hand-derived values.
    v = '0;
    model(v, mh, mf, ml);
    chk("model zero lat", ml, 94);
    chk("model zero fail", longint'(mf), 0);
    v[8*75 +: 8] = 8'd76;
    model(v, mh, mf, ml);
    chk("model limit_gt_w fail", longint'(mf), 1);

    // All-zero encoding.
    v = '0;
    run_case(v, "zero");
    chk("zero h_pop", popc(h), 0);

    // Single hint h[0][5].
    v = '0; v[7:0] = 8'd5;
    for (int r = 0; r < K; r++) v[8*(W+r) +: 8] = 8'd1;
    run_case(v, "single");
    chk("single h05", longint'(h[0][5]), 1);
    chk("single h_pop", popc(h), 1);
    chk("single fail", longint'(fail), 0);

    // Full 75 hints: rows of 10 (last row 5), positions 20*j + r.
    v3 = '0;
    begin
      int idx; idx = 0;
      for (int r = 0; r < K; r++) begin
        for (int j = 0; j < ((r == K - 1) ? 5 : 10); j++) begin
          v3[8*idx +: 8] = 8'(20 * j + r);
          idx++;
        end
        v3[8*(W+r) +: 8] = 8'(idx);
      end
    end
    run_case(v3, "full");
    chk("full h_pop", popc(h), 75);
    chk("full h[7][87]", longint'(h[7][87]), 1);
    chk("full fail", longint'(fail), 0);

    // Malformed encodings.
    v = '0; v[8*75 +: 8] = 8'd76;
    run_case(v, "limit_gt_w");
    chk("limit_gt_w fail", longint'(fail), 1);
    chk("limit_gt_w h_pop", popc(h), 0);

    v = '0; v[7:0] = 8'd9; v[15:8] = 8'd9;
    for (int r = 0; r < K; r++) v[8*(W+r) +: 8] = 8'd2;
    run_case(v, "nonincr");
    chk("nonincr fail", longint'(fail), 1);
    chk("nonincr h_pop", popc(h), 0);

    v = '0; v[8*3 +: 8] = 8'd7;
    run_case(v, "tail");
    chk("tail fail", longint'(fail), 1);

    v = '0; v[7:0] = 8'd1; v[15:8] = 8'd2; v[23:16] = 8'd3;
    v[8*75 +: 8] = 8'd3; v[8*76 +: 8] = 8'd1;
    run_case(v, "limit_dec");
    chk("limit_dec fail", longint'(fail), 1);
    chk("limit_dec h_pop", popc(h), 0);

    // Reset in the middle of DECODE, then a clean decode.
    @(negedge clk); y = v3; startpin = 1'b1;
    @(negedge clk); startpin = 1'b0;
    repeat (20) @(negedge clk);
    exp_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst endpin", longint'(endpin), 0);
    chk("midrst fail", longint'(fail), 0);
    chk("midrst h_pop", popc(h), 0);
    @(negedge clk); rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    chk("midrst idle", longint'(endpin), 0);
    run_case(v3, "after_rst");
    chk("after_rst h_pop", popc(h), 75);

    // startpin held high through DONE: no restart.
    v = '0; v[7:0] = 8'd200;
    for (int r = 1; r < K; r++) v[8*(W+r) +: 8] = 8'd1;
    v[8*75 +: 8] = 8'd1;
    model(v, mh, mf, ml);
    @(negedge clk);
    exp_h = mh; exp_fail = mf; exp_valid = 1'b1; y = v; startpin = 1'b1;
    @(posedge clk); #1;
    chk("held endpin_clear", longint'(endpin), 0);
    cyc = 0;
    while (!endpin && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("held latency", cyc, ml);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      chk("held endpin", longint'(endpin), 1);
    end
    @(negedge clk); startpin = 1'b0;
    @(posedge clk);
    run_case(v3, "rearm");

    // Random encodings, some corrupted.
    for (int t = 0; t < 40; t++) begin
      gen_rand(v);
      run_case(v, "rand");
    end

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
